sync_fifo_fwft: RTL
===================

SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16: number of entries; power of two, >= 2.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: data word width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH): pointer index width.
REQ-004 The block SHALL have parameter FWFT, default 1: 1 = first-word-fall-through read, 0 = registered read-request mode.
REQ-005 The block SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-006 The block SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port i_flush, input, 1: synchronous empty request.
REQ-008 The block SHALL have port i_clr_err, input, 1: clears sticky error flags.
REQ-009 The block SHALL have write ports: i_valid_s (input, 1, write request), i_datain (input, DATA_WIDTH, write data), o_ready_s (output, 1, write accept).
REQ-010 The block SHALL have read ports: i_ready_m (input, 1, read/pop request), o_valid_m (output, 1, o_dataout valid), o_dataout (output, DATA_WIDTH, read data).
REQ-011 The block SHALL have threshold inputs i_almostfull_lvl and i_almostempty_lvl, each ADDR_WIDTH+1 bits.
REQ-012 The block SHALL have status outputs o_full, o_almostfull, o_empty, o_almostempty (1 bit each), o_count (ADDR_WIDTH+1 bits, occupancy), o_overflow and o_underflow (1 bit each, sticky).

Function
REQ-013 Pointers SHALL be ADDR_WIDTH+1 bits; full = MSBs differ and index bits equal; empty = pointers equal; wrap-around SHALL be seamless.
REQ-014 o_ready_s SHALL equal !o_full; a write SHALL be accepted iff i_valid_s && o_ready_s, storing i_datain at the write index and incrementing the write pointer.
REQ-015 FWFT=1: o_valid_m SHALL equal !o_empty; o_dataout SHALL present the head entry with zero latency; a pop SHALL occur iff i_ready_m && o_valid_m.
REQ-016 FWFT=0: a pop SHALL occur iff i_ready_m && !o_empty; popped data SHALL appear on registered o_dataout one cycle later, with o_valid_m high for exactly that cycle; o_dataout SHALL hold between pops.
REQ-017 o_count SHALL be registered: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop; range 0..FIFO_DEPTH.
REQ-018 All status flags SHALL be registered and consistent with o_count in the same cycle.
REQ-019 o_almostfull SHALL be 1 iff (FIFO_DEPTH - o_count) <= i_almostfull_lvl; o_almostempty SHALL be 1 iff o_count <= i_almostempty_lvl.
REQ-020 When full, a write SHALL be rejected even with a simultaneous pop; there SHALL be no write-through bypass.
REQ-021 When empty, a simultaneous write SHALL be accepted and no pop SHALL occur; in FWFT=1 the word SHALL be visible the next cycle.
REQ-022 i_valid_s while o_full SHALL set o_overflow; in FWFT=0, i_ready_m while o_empty SHALL set o_underflow; o_underflow SHALL never set in FWFT=1.
REQ-023 Sticky flags SHALL clear only on i_clr_err or i_rst; a same-cycle set condition SHALL take priority over i_clr_err.
REQ-024 i_flush SHALL zero both pointers and o_count next cycle, discarding any same-cycle write or pop; sticky flags SHALL be unaffected; in FWFT=0, o_valid_m SHALL be 0 the next cycle.
REQ-025 Memory SHALL be an unreset register array written on i_clk.

Reset
REQ-026 While i_rst is high at a rising edge, pointers and o_count SHALL go to 0, o_empty=1, o_almostempty=1, o_full=0, o_ready_s=1, o_valid_m=0, o_overflow=0, o_underflow=0, o_dataout=0 (FWFT=0).
REQ-027 i_rst SHALL take priority over i_flush, writes and pops; memory contents are not cleared.
REQ-028 Reset asserted mid-burst SHALL discard all contents; the first write after release SHALL be the first word read.

Verification
REQ-029 DEPTH=16, FWFT=1: write 0x01..0x10 -> o_full=1, o_count=16; 17th write with i_valid_s=1 -> rejected, o_overflow=1; then drain -> data 0x01..0x10 in order, o_empty=1.
REQ-030 FWFT=0: pop on empty -> o_underflow=1, o_valid_m stays 0; write 0xAA, pop next cycle -> o_valid_m=1 with 0xAA one cycle after the pop.
REQ-031 Simultaneous write+pop for 40 cycles at o_count=5 -> o_count stays 5, order preserved across pointer wrap.
REQ-032 i_almostfull_lvl=2, i_almostempty_lvl=3: fill -> o_almostfull rises at o_count=14; drain -> o_almostempty rises at o_count=3.
REQ-033 Fill to 9, assert i_flush with concurrent write -> o_count=0, o_empty=1, o_overflow unchanged; i_clr_err -> sticky flags 0.
REQ-034 Assert i_rst at o_count=7 -> all outputs at REQ-026 values next cycle; write 0x55 then read -> 0x55.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read.
// All status flags are registered and derived from the same next-state values.
module sync_fifo_fwft #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int FWFT       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_clr_err,
    input  logic                  i_valid_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_ready_s,
    input  logic                  i_ready_m,
    output logic                  o_valid_m,
    output logic [DATA_WIDTH-1:0] o_dataout,
    input  logic [ADDR_WIDTH:0]   i_almostfull_lvl,
    input  logic [ADDR_WIDTH:0]   i_almostempty_lvl,
    output logic                  o_full,
    output logic                  o_almostfull,
    output logic                  o_empty,
    output logic                  o_almostempty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almostfull;
    logic                  r_almostempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_almostfull_nxt;
    logic                  w_almostempty_nxt;
    logic                  w_underflow_set;

    // A full FIFO never accepts, even if a pop happens in the same cycle.
    assign w_wr_en  = i_valid_s && !r_full;
    assign w_rd_en  = i_ready_m && !r_empty;
    assign w_wr_idx = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_idx = r_rd_ptr[ADDR_WIDTH-1:0];

    assign w_underflow_set = (FWFT == 0) && i_ready_m && r_empty;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (i_rst || i_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_wr_en) begin
                w_wr_ptr_nxt = r_wr_ptr + LP_ONE;
            end
            if (w_rd_en) begin
                w_rd_ptr_nxt = r_rd_ptr + LP_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   w_count_nxt = r_count + LP_ONE;
                2'b01:   w_count_nxt = r_count - LP_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    assign w_full_nxt  = (w_wr_ptr_nxt[ADDR_WIDTH] != w_rd_ptr_nxt[ADDR_WIDTH]) &&
                         (w_wr_ptr_nxt[ADDR_WIDTH-1:0] == w_rd_ptr_nxt[ADDR_WIDTH-1:0]);
    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    assign w_almostfull_nxt  = (LP_DEPTH - w_count_nxt) <= i_almostfull_lvl;
    assign w_almostempty_nxt = w_count_nxt <= i_almostempty_lvl;

    always_ff @(posedge i_clk) begin
        r_wr_ptr      <= w_wr_ptr_nxt;
        r_rd_ptr      <= w_rd_ptr_nxt;
        r_count       <= w_count_nxt;
        r_full        <= w_full_nxt;
        r_empty       <= w_empty_nxt;
        r_almostfull  <= w_almostfull_nxt;
        r_almostempty <= w_almostempty_nxt;
    end

    // Sticky errors: a new event in the same cycle wins over a clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_valid_s && r_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end else if (i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_rst && !i_flush) begin
            r_mem[w_wr_idx] <= i_datain;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_dataout = r_mem[w_rd_idx];
            assign o_valid_m = !r_empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_dataout;
            logic                  r_valid_m;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_dataout <= '0;
                    r_valid_m <= 1'b0;
                end else if (i_flush) begin
                    r_valid_m <= 1'b0;
                end else begin
                    r_valid_m <= w_rd_en;
                    if (w_rd_en) begin
                        r_dataout <= r_mem[w_rd_idx];
                    end
                end
            end

            assign o_dataout = r_dataout;
            assign o_valid_m = r_valid_m;
        end
    endgenerate

    assign o_ready_s     = !r_full;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_almostfull  = r_almostfull;
    assign o_almostempty = r_almostempty;
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;

endmodule
